reg_writeback: RTL and testbench
================================

Name: reg_writeback

Overview:
- Write-side master for the 8 x 16-bit register file; it drives the file's clk/write_en/write_addr/write_data write port.
- Merges two result sources onto the single write port:
  - single-cycle ALU results, which carry no backpressure;
  - load results, which use a valid/ready handshake and are buffered in a small in-order queue.
- Keeps a pending-destination scoreboard for outstanding loads, so issue logic can stall reads of registers not yet written back.

Parameters:
- DATA_W, 16, register data width.
- ADDR_W, 3, register address width; NUM_REGS = 2**ADDR_W = 8.
- LQ_DEPTH, 2, load queue depth in entries; must be 2 or greater.

Ports:
- clk  in  1  rising-edge clock, shared with the register file.
- rst  in  1  synchronous, active-high reset.
- alu_valid  in  1  ALU result present this cycle; always accepted.
- alu_addr  in  ADDR_W  ALU destination register.
- alu_data  in  DATA_W  ALU result.
- ld_valid  in  1  load result offered.
- ld_ready  out  1  load result accepted when ld_valid && ld_ready.
- ld_addr  in  ADDR_W  load destination register.
- ld_data  in  DATA_W  load data.
- rsv_valid  in  1  a load was issued; reserve its destination.
- rsv_addr  in  ADDR_W  destination register to reserve.
- write_en  out  1  to register file; registered.
- write_addr  out  ADDR_W  to register file; registered.
- write_data  out  DATA_W  to register file; registered.
- pending  out  NUM_REGS  bitmap; bit i = 1 means a load to ri is outstanding.
- lq_count  out  $clog2(LQ_DEPTH+1)  current load queue occupancy.
- rsv_err  out  1  sticky; set when a reservation targets an already-pending register.

Behaviour:
- Reset (rst=1 at a rising edge):
  - write_en=0, write_addr=0, write_data=0;
  - pending=0, rsv_err=0, lq_count=0, all queue contents dropped;
  - ld_ready=0 while rst=1.
- Reset mid-operation: queued or in-flight loads are discarded; no write issues after reset from pre-reset state.
- Write-source priority, evaluated each cycle N:
  1. alu_valid=1: the ALU result is selected.
  2. Otherwise, lq_count>0: the queue head is popped and selected.
  3. Otherwise, lq_count=0 and an ld handshake occurs: bypass, and the load is selected directly.
  4. Otherwise: no write.
- The selected write appears on write_* in cycle N+1 with write_en=1. The register file commits it at the end of N+1. Latency is 1 cycle for ALU results and for bypassed loads.
- ld_ready = !rst && (lq_count < LQ_DEPTH). It depends on registered state only, never combinationally on alu_valid.
- An accepted load that is not bypassed is pushed to the queue tail. Loads commit strictly in acceptance order.
- A push and a pop in the same cycle leave lq_count unchanged. A full queue cannot receive a push, because ld_ready=0.
- A continuous alu_valid starves the queue. Issue logic guarantees bubbles; no internal anti-starvation mechanism.
- A register-0 write is an ordinary write; there is no hardwired zero.
- Scoreboard:
  - rsv_valid sets pending[rsv_addr] at the edge ending cycle N.
  - A load-sourced commit (write_en=1 and source=load in cycle M) clears pending[write_addr] at the edge ending M.
  - The cleared bit is low from M+1.
  - A same-cycle set and clear on the same address leave the bit set; the set wins.
  - rsv_valid to an address with pending=1 sets rsv_err, which stays set until rst; pending stays 1.
  - ALU writes never modify pending.
- Internal state: a source register {SRC_NONE, SRC_ALU, SRC_LD} travels with write_*; queue read/write pointers wrap modulo LQ_DEPTH.

Decomposition:
- Shared package (e.g. risc_pkg):
  - constants DATA_W=16, ADDR_W=3, NUM_REGS=8;
  - wb_src_t enum {SRC_NONE, SRC_ALU, SRC_LD};
  - a typedef for the {addr, data} write packet.
- One sub-module, wb_load_queue: a parameterised LQ_DEPTH FIFO of write packets.
  - Ports: push, pop, head, count, full, empty.
  - Synchronous active-high reset.

Test Plan:
1. Reset, then alu_valid with addr=3, data=35 in cycle N → in N+1 write_en=1, write_addr=3, write_data=35; in N+2 write_en=0; a read of r3 afterwards returns 35.
2. rsv addr=4, then ld_valid addr=4, data=47 with the queue empty and the ALU idle → ld_ready=1; next cycle writes 4/47 (bypass); pending[4] is 1 until the commit cycle and 0 the cycle after; lq_count stays 0.
3. Same cycle: alu 5/256 and ld 6/7 → write 5/256 in N+1 with lq_count=1; write 6/7 in N+2; lq_count=0 in N+2.
4. alu_valid held 4 cycles while loads 1/11, 2/22, 3/33 are offered back-to-back → two loads accepted; ld_ready=0 with lq_count=2; after the ALU stops, writes are 1/11, 2/22, 3/33 in order with no loss or duplication.
5. Queue at count 2 with pending=8'h30; assert rst for 1 cycle → next cycle lq_count=0, pending=0, write_en=0; no queued write ever appears.
6. rsv addr=2 in the same cycle as a load commit to r2 → pending[2] stays 1; then rsv addr=2 again → rsv_err=1, which persists across idle cycles until rst.

Source files
------------

// File: rtl/reg_writeback_pkg.sv
// Shared types and constants for the register-file write-back path.
package reg_writeback_pkg;

  localparam int unsigned DATA_W   = 16;
  localparam int unsigned ADDR_W   = 3;
  localparam int unsigned NUM_REGS = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_ALU,
    SRC_LD
  } wb_src_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_pkt_t;

endpackage

// File: rtl/reg_writeback_load_queue.sv
// In-order FIFO of load write packets; head is valid whenever count is non-zero.
module wb_load_queue #(
  parameter int unsigned LQ_DEPTH = 2,
  parameter type         pkt_t    = reg_writeback_pkg::wb_pkt_t,
  localparam int unsigned CNT_W   = $clog2(LQ_DEPTH + 1),
  localparam int unsigned PTR_W   = $clog2(LQ_DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  pkt_t             push_pkt,
  input  logic             pop,
  output pkt_t             head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  pkt_t             mem [LQ_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(LQ_DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_pkt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == PTR_W'(LQ_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= (rd_ptr == PTR_W'(LQ_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/reg_writeback.sv
// Register-file write port master: ALU results take priority, loads are queued
// in order, and a pending bitmap tracks destinations of outstanding loads.
module reg_writeback #(
  parameter int unsigned  DATA_W   = reg_writeback_pkg::DATA_W,
  parameter int unsigned  ADDR_W   = reg_writeback_pkg::ADDR_W,
  parameter int unsigned  LQ_DEPTH = 2,
  localparam int unsigned NUM_REGS = 2 ** ADDR_W,
  localparam int unsigned CNT_W    = $clog2(LQ_DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                alu_valid,
  input  logic [ADDR_W-1:0]   alu_addr,
  input  logic [DATA_W-1:0]   alu_data,
  input  logic                ld_valid,
  output logic                ld_ready,
  input  logic [ADDR_W-1:0]   ld_addr,
  input  logic [DATA_W-1:0]   ld_data,
  input  logic                rsv_valid,
  input  logic [ADDR_W-1:0]   rsv_addr,
  output logic                write_en,
  output logic [ADDR_W-1:0]   write_addr,
  output logic [DATA_W-1:0]   write_data,
  output logic [NUM_REGS-1:0] pending,
  output logic [CNT_W-1:0]    lq_count,
  output logic                rsv_err
);

  import reg_writeback_pkg::*;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } pkt_t;

  wb_src_t       wr_src;
  wb_src_t       sel_src;
  pkt_t          sel_pkt;
  pkt_t          lq_head;
  pkt_t          ld_pkt;
  logic          lq_full;
  logic          lq_empty;
  logic          ld_accept;
  logic          lq_pop;
  logic          lq_push;
  logic          bypass;
  logic [NUM_REGS-1:0] pending_next;

  assign ld_pkt    = '{addr: ld_addr, data: ld_data};
  assign ld_ready  = !rst && !lq_full;
  assign ld_accept = ld_valid && ld_ready;
  assign lq_pop    = !alu_valid && !lq_empty;
  // Bypass only when nothing older is queued, so acceptance order is kept.
  assign bypass    = !alu_valid && lq_empty && ld_accept;
  assign lq_push   = ld_accept && !bypass;

  wb_load_queue #(
    .LQ_DEPTH (LQ_DEPTH),
    .pkt_t    (pkt_t)
  ) u_lq (
    .clk      (clk),
    .rst      (rst),
    .push     (lq_push),
    .push_pkt (ld_pkt),
    .pop      (lq_pop),
    .head     (lq_head),
    .count    (lq_count),
    .full     (lq_full),
    .empty    (lq_empty)
  );

  always_comb begin
    sel_src = SRC_NONE;
    sel_pkt = '0;
    if (alu_valid) begin
      sel_src = SRC_ALU;
      sel_pkt = '{addr: alu_addr, data: alu_data};
    end else if (lq_pop) begin
      sel_src = SRC_LD;
      sel_pkt = lq_head;
    end else if (bypass) begin
      sel_src = SRC_LD;
      sel_pkt = ld_pkt;
    end
  end

  // Clear from the committing load first, so a same-cycle reservation wins.
  always_comb begin
    pending_next = pending;
    if (write_en && wr_src == SRC_LD) pending_next[write_addr] = 1'b0;
    if (rsv_valid) pending_next[rsv_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      write_en   <= 1'b0;
      write_addr <= '0;
      write_data <= '0;
      wr_src     <= SRC_NONE;
      pending    <= '0;
      rsv_err    <= 1'b0;
    end else begin
      write_en <= (sel_src != SRC_NONE);
      wr_src   <= sel_src;
      if (sel_src != SRC_NONE) begin
        write_addr <= sel_pkt.addr;
        write_data <= sel_pkt.data;
      end
      pending <= pending_next;
      if (rsv_valid && pending[rsv_addr]) rsv_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_reg_writeback.sv
// Directed bench for reg_writeback with a behavioural register file on write_*.
module tb_reg_writeback;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid;
  logic [2:0]  alu_addr;
  logic [15:0] alu_data;
  logic        ld_valid;
  logic        ld_ready;
  logic [2:0]  ld_addr;
  logic [15:0] ld_data;
  logic        rsv_valid;
  logic [2:0]  rsv_addr;
  logic        write_en;
  logic [2:0]  write_addr;
  logic [15:0] write_data;
  logic [7:0]  pending;
  logic [1:0]  lq_count;
  logic        rsv_err;

  logic [15:0] rf [8];
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  reg_writeback #(.DATA_W(16), .ADDR_W(3), .LQ_DEPTH(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .alu_valid  (alu_valid),
    .alu_addr   (alu_addr),
    .alu_data   (alu_data),
    .ld_valid   (ld_valid),
    .ld_ready   (ld_ready),
    .ld_addr    (ld_addr),
    .ld_data    (ld_data),
    .rsv_valid  (rsv_valid),
    .rsv_addr   (rsv_addr),
    .write_en   (write_en),
    .write_addr (write_addr),
    .write_data (write_data),
    .pending    (pending),
    .lq_count   (lq_count),
    .rsv_err    (rsv_err)
  );

  always @(posedge clk) if (write_en) rf[write_addr] <= write_data;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alu_valid = 1'b0; alu_addr = '0; alu_data = '0;
    ld_valid  = 1'b0; ld_addr  = '0; ld_data  = '0;
    rsv_valid = 1'b0; rsv_addr = '0;
  endtask

  logic [18:0] exp_wr [7];
  logic [18:0] got_wr [$];
  int ld_idx;
  logic hs;

  initial begin
    idle_inputs();
    rst = 1'b1;
    tick(); tick();
    chk("rst_ld_ready", ld_ready, 0);
    chk("rst_we", write_en, 0);
    chk("rst_waddr", write_addr, 0);
    chk("rst_wdata", write_data, 0);
    chk("rst_pending", pending, 0);
    chk("rst_count", lq_count, 0);
    chk("rst_err", rsv_err, 0);
    rst = 1'b0;
    #1;
    chk("ld_ready_after_rst", ld_ready, 1);

    // 1: ALU write, one-cycle latency
    alu_valid = 1; alu_addr = 3; alu_data = 35;
    tick();
    idle_inputs();
    chk("t1_we", write_en, 1);
    chk("t1_addr", write_addr, 3);
    chk("t1_data", write_data, 35);
    tick();
    chk("t1_we_off", write_en, 0);
    chk("t1_rf3", rf[3], 35);

    // 2: reserved load bypasses the empty queue
    rsv_valid = 1; rsv_addr = 4;
    tick();
    idle_inputs();
    chk("t2_pend_set", pending, 8'h10);
    ld_valid = 1; ld_addr = 4; ld_data = 47;
    #1;
    chk("t2_ready", ld_ready, 1);
    tick();
    idle_inputs();
    chk("t2_we", write_en, 1);
    chk("t2_addr", write_addr, 4);
    chk("t2_data", write_data, 47);
    chk("t2_pend_commit", pending, 8'h10);
    chk("t2_count", lq_count, 0);
    tick();
    chk("t2_pend_clr", pending, 0);
    chk("t2_we_off", write_en, 0);

    // 3: ALU and load collide; load is queued one cycle
    alu_valid = 1; alu_addr = 5; alu_data = 256;
    ld_valid = 1; ld_addr = 6; ld_data = 7;
    tick();
    idle_inputs();
    chk("t3_alu_addr", write_addr, 5);
    chk("t3_alu_data", write_data, 256);
    chk("t3_count1", lq_count, 1);
    tick();
    chk("t3_ld_we", write_en, 1);
    chk("t3_ld_addr", write_addr, 6);
    chk("t3_ld_data", write_data, 7);
    chk("t3_count0", lq_count, 0);
    tick();

    // 4: ALU holds the port 4 cycles while three loads are offered
    exp_wr[0] = {3'd7, 16'd100}; exp_wr[1] = {3'd7, 16'd101};
    exp_wr[2] = {3'd7, 16'd102}; exp_wr[3] = {3'd7, 16'd103};
    exp_wr[4] = {3'd1, 16'd11};  exp_wr[5] = {3'd2, 16'd22};
    exp_wr[6] = {3'd3, 16'd33};
    ld_idx = 0;
    for (int k = 0; k < 12; k++) begin
      alu_valid = (k < 4);
      alu_addr  = 7;
      alu_data  = 16'(100 + k);
      ld_valid  = (ld_idx < 3);
      ld_addr   = 3'(ld_idx + 1);
      ld_data   = 16'(11 * (ld_idx + 1));
      #1;
      if (k == 2) begin
        chk("t4_ready_full", ld_ready, 0);
        chk("t4_count_full", lq_count, 2);
      end
      hs = ld_valid && ld_ready;
      tick();
      if (hs) ld_idx++;
      if (write_en) got_wr.push_back({write_addr, write_data});
    end
    idle_inputs();
    chk("t4_nwrites", got_wr.size(), 7);
    for (int i = 0; i < 7; i++)
      chk($sformatf("t4_wr%0d", i), (i < got_wr.size()) ? got_wr[i] : 19'h7ffff, exp_wr[i]);

    // 5: reset with a full queue and two reservations discards everything
    alu_valid = 1; alu_addr = 0; alu_data = 1;
    ld_valid = 1; ld_addr = 4; ld_data = 16'h44;
    rsv_valid = 1; rsv_addr = 4;
    tick();
    alu_data = 2; ld_addr = 5; ld_data = 16'h55; rsv_addr = 5;
    tick();
    idle_inputs();
    chk("t5_count_full", lq_count, 2);
    chk("t5_pending", pending, 8'h30);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_count", lq_count, 0);
    chk("t5_pending_clr", pending, 0);
    chk("t5_we", write_en, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("t5_no_write%0d", i), write_en, 0);
    end

    // 6: reservation coinciding with a load commit wins; re-reserve is an error
    ld_valid = 1; ld_addr = 2; ld_data = 16'h22;
    tick();
    idle_inputs();
    chk("t6_commit_we", write_en, 1);
    rsv_valid = 1; rsv_addr = 2;
    tick();
    idle_inputs();
    chk("t6_pend_kept", pending, 8'h04);
    chk("t6_no_err", rsv_err, 0);
    rsv_valid = 1; rsv_addr = 2;
    tick();
    idle_inputs();
    chk("t6_err_set", rsv_err, 1);
    tick(); tick(); tick();
    chk("t6_err_sticky", rsv_err, 1);
    chk("t6_pend_still", pending, 8'h04);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_err_rst", rsv_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
